resize_addr_gen: RTL and testbench

//  Address/weight sequencer for a separable bilinear upscale of one feature-map plane.
//  - Pass 0 (horizontal): interpolates each source row into a temp buffer.
//  - Pass 1 (vertical): interpolates temp rows into the destination buffer.
//  - Emits one tuple per enabled cycle: two neighbour read addresses, a write address
//    and a Q0.16 weight. A downstream lerp datapath computes
//    out = src1 + frac*(src2-src1) and writes it to des_addr.

---
 rtl/resize_addr_gen.sv | 141 ++++++++++++++
 tb/tb_resize_addr_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/resize_addr_gen.sv
// Address/weight sequencer for a separable bilinear upscale: horizontal pass into a temp plane, then vertical pass.
// Optional RESIZE_DONE_PULSE_EN: done pulses for one cycle and the sequencer rearms; otherwise done is sticky.
module resize_addr_gen #(
  parameter int ADDR_SZ  = 16,
  parameter int SRC_W    = 4,
  parameter int SRC_H    = 4,
  parameter int DST_W    = 8,
  parameter int DST_H    = 8,
  parameter int SRC_BASE = 0,
  parameter int TMP_BASE = 256,
  parameter int DST_BASE = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [ADDR_SZ-1:0] src_addr1,
  output logic [ADDR_SZ-1:0] src_addr2,
  output logic [ADDR_SZ-1:0] des_addr,
  output logic               stage_flag,
  output logic [15:0]        fraction_part,
  output logic               done
);

  localparam logic [31:0] STEP_X = 32'(((SRC_W - 1) * 65536) / (DST_W - 1));
  localparam logic [31:0] STEP_Y = 32'(((SRC_H - 1) * 65536) / (DST_H - 1));

  localparam logic [ADDR_SZ-1:0] SB = ADDR_SZ'(SRC_BASE);
  localparam logic [ADDR_SZ-1:0] TB = ADDR_SZ'(TMP_BASE);
  localparam logic [ADDR_SZ-1:0] DB = ADDR_SZ'(DST_BASE);
  localparam logic [ADDR_SZ-1:0] SW = ADDR_SZ'(SRC_W);
  localparam logic [ADDR_SZ-1:0] DW = ADDR_SZ'(DST_W);

  typedef enum logic [1:0] {IDLE, HPASS, VPASS, DONE} state_t;
  state_t state;

  // Counters describe the next tuple to issue.
  logic               nxt_v;
  logic               last;
  logic [15:0]        col;
  logic [15:0]        row;
  logic [31:0]        pos_x;
  logic [31:0]        pos_y;
  logic [ADDR_SZ-1:0] row_off;   // row * DST_W (temp row in HPASS, dest row in VPASS)
  logic [ADDR_SZ-1:0] src_off;   // row * SRC_W
  logic [ADDR_SZ-1:0] iy_off;    // floor(pos_y) * DST_W

  logic [15:0]        ix, ix2, iy;
  logic [31:0]        pos_y_nxt;
  logic [ADDR_SZ-1:0] t_src1, t_src2, t_des;
  logic [15:0]        t_frac;

  always_comb begin
    ix        = pos_x[31:16];
    ix2       = (ix == 16'(SRC_W - 1)) ? ix : ix + 16'd1;
    iy        = pos_y[31:16];
    pos_y_nxt = pos_y + STEP_Y;
    if (!nxt_v) begin
      t_src1 = SB + src_off + ADDR_SZ'(ix);
      t_src2 = SB + src_off + ADDR_SZ'(ix2);
      t_des  = TB + row_off + ADDR_SZ'(col);
      t_frac = pos_x[15:0];
    end else begin
      t_src1 = TB + iy_off + ADDR_SZ'(col);
      t_src2 = TB + iy_off + ((iy == 16'(SRC_H - 1)) ? '0 : DW) + ADDR_SZ'(col);
      t_des  = DB + row_off + ADDR_SZ'(col);
      t_frac = pos_y[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      nxt_v         <= 1'b0;
      last          <= 1'b0;
      col           <= '0;
      row           <= '0;
      pos_x         <= '0;
      pos_y         <= '0;
      row_off       <= '0;
      src_off       <= '0;
      iy_off        <= '0;
      src_addr1     <= '0;
      src_addr2     <= '0;
      des_addr      <= '0;
      stage_flag    <= 1'b0;
      fraction_part <= '0;
      done          <= 1'b0;
    end else if (state == DONE) begin
`ifdef RESIZE_DONE_PULSE_EN
      state   <= IDLE;
      done    <= 1'b0;
      nxt_v   <= 1'b0;
      last    <= 1'b0;
      col     <= '0;
      row     <= '0;
      pos_x   <= '0;
      pos_y   <= '0;
      row_off <= '0;
      src_off <= '0;
      iy_off  <= '0;
`endif
    end else if (enable) begin
      if (last) begin
        state <= DONE;
        done  <= 1'b1;
      end else begin
        state         <= nxt_v ? VPASS : HPASS;
        src_addr1     <= t_src1;
        src_addr2     <= t_src2;
        des_addr      <= t_des;
        fraction_part <= t_frac;
        stage_flag    <= nxt_v;
        if (col != 16'(DST_W - 1)) begin
          col   <= col + 16'd1;
          pos_x <= pos_x + STEP_X;
        end else if (!nxt_v && row == 16'(SRC_H - 1)) begin
          nxt_v   <= 1'b1;
          col     <= '0;
          pos_x   <= '0;
          row     <= '0;
          row_off <= '0;
          pos_y   <= '0;
          iy_off  <= '0;
        end else if (nxt_v && row == 16'(DST_H - 1)) begin
          last <= 1'b1;
        end else begin
          col     <= '0;
          pos_x   <= '0;
          row     <= row + 16'd1;
          row_off <= row_off + DW;
          src_off <= src_off + SW;
          pos_y   <= pos_y_nxt;
          // Upscale keeps STEP_Y below one, so the integer row moves by at most one.
          if (pos_y_nxt[31:16] != pos_y[31:16])
            iy_off <= iy_off + DW;
        end
      end
    end
  end

endmodule

// File: tb/tb_resize_addr_gen.sv
// Directed test of resize_addr_gen at default parameters (sticky-done build).
module tb_resize_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] src_addr1, src_addr2, des_addr, fraction_part;
  logic        stage_flag, done;

  int checks = 0;
  int errors = 0;

  resize_addr_gen dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_addr1(src_addr1), .src_addr2(src_addr2), .des_addr(des_addr),
    .stage_flag(stage_flag), .fraction_part(fraction_part), .done(done)
  );

  always #5 clk = ~clk;

  logic [65:0] got;
  assign got = {src_addr1, src_addr2, des_addr, fraction_part, stage_flag, done};

  function automatic logic [65:0] tup(input int s1, input int s2, input int d,
                                      input int f, input int st, input int dn);
    return {16'(s1), 16'(s2), 16'(d), 16'(f), 1'(st), 1'(dn)};
  endfunction

  // Advance n rising edges, then settle 1 time unit before sampling.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    adv(3);
    checks++;
    if (got !== tup(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, tup(0, 0, 0, 0, 0, 0));
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", done);
    end
  endtask

  task automatic test_hpass;
    reset = 1'b0; enable = 1'b1;
    adv(1);
    checks++;
    if (got !== tup(0, 1, 256, 0, 0, 0)) begin
      errors++; $display("FAIL tuple0 got=%h exp=%h", got, tup(0, 1, 256, 0, 0, 0));
    end
    adv(1);
    checks++;
    if (got !== tup(0, 1, 257, 28086, 0, 0)) begin
      errors++; $display("FAIL tuple1 got=%h exp=%h", got, tup(0, 1, 257, 28086, 0, 0));
    end
    adv(6);
    checks++;
    if (got !== tup(2, 3, 263, 65530, 0, 0)) begin
      errors++; $display("FAIL tuple7 got=%h exp=%h", got, tup(2, 3, 263, 65530, 0, 0));
    end
    adv(1);
    checks++;
    if (got !== tup(4, 5, 264, 0, 0, 0)) begin
      errors++; $display("FAIL tuple8 got=%h exp=%h", got, tup(4, 5, 264, 0, 0, 0));
    end
  endtask

  task automatic test_hold;
    enable = 1'b0;
    adv(5);
    checks++;
    if (got !== tup(4, 5, 264, 0, 0, 0)) begin
      errors++; $display("FAIL hold_frozen got=%h exp=%h", got, tup(4, 5, 264, 0, 0, 0));
    end
    enable = 1'b1;
    adv(1);
    // c=1 of row 1: pos=28086 -> i=0
    checks++;
    if (got !== tup(4, 5, 265, 28086, 0, 0)) begin
      errors++; $display("FAIL resume_tuple9 got=%h exp=%h", got, tup(4, 5, 265, 28086, 0, 0));
    end
  endtask

  task automatic test_pass_boundary;
    adv(22);
    checks++;
    if (got !== tup(14, 15, 287, 65530, 0, 0)) begin
      errors++; $display("FAIL tuple31 got=%h exp=%h", got, tup(14, 15, 287, 65530, 0, 0));
    end
    adv(1);
    checks++;
    if (got !== tup(256, 264, 512, 0, 1, 0)) begin
      errors++; $display("FAIL tuple32 got=%h exp=%h", got, tup(256, 264, 512, 0, 1, 0));
    end
    adv(8);
    // rr=1, c=0: pos_y=28086 -> i=0
    checks++;
    if (got !== tup(256, 264, 520, 28086, 1, 0)) begin
      errors++; $display("FAIL tuple40 got=%h exp=%h", got, tup(256, 264, 520, 28086, 1, 0));
    end
    adv(55);
    // rr=7, c=7: i=2 -> src1=256+16+7, src2=256+24+7
    checks++;
    if (got !== tup(279, 287, 575, 65530, 1, 0)) begin
      errors++; $display("FAIL tuple95 got=%h exp=%h", got, tup(279, 287, 575, 65530, 1, 0));
    end
  endtask

  task automatic test_done;
    adv(1);
    checks++;
    if (got !== tup(279, 287, 575, 65530, 1, 1)) begin
      errors++; $display("FAIL done_edge97 got=%h exp=%h", got, tup(279, 287, 575, 65530, 1, 1));
    end
    enable = 1'b0;
    adv(2);
    enable = 1'b1;
    adv(4);
    checks++;
    if (got !== tup(279, 287, 575, 65530, 1, 1)) begin
      errors++; $display("FAIL done_sticky got=%h exp=%h", got, tup(279, 287, 575, 65530, 1, 1));
    end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1; enable = 1'b0;
    adv(1);
    reset = 1'b0; enable = 1'b1;
    adv(41);
    checks++;
    if (got !== tup(256, 264, 520, 28086, 1, 0)) begin
      errors++; $display("FAIL rerun_tuple40 got=%h exp=%h", got, tup(256, 264, 520, 28086, 1, 0));
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (got !== tup(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", got, tup(0, 0, 0, 0, 0, 0));
    end
    adv(2);
    reset = 1'b0;
    adv(1);
    checks++;
    if (got !== tup(0, 1, 256, 0, 0, 0)) begin
      errors++; $display("FAIL restart_tuple0 got=%h exp=%h", got, tup(0, 1, 256, 0, 0, 0));
    end
    adv(1);
    checks++;
    if (got !== tup(0, 1, 257, 28086, 0, 0)) begin
      errors++; $display("FAIL restart_tuple1 got=%h exp=%h", got, tup(0, 1, 257, 28086, 0, 0));
    end
  endtask

  initial begin
    test_reset;
    test_hpass;
    test_hold;
    test_pass_boundary;
    test_done;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
